digit_collector: RTL and testbench

- Downstream consumer of the 1 Hz decimal random-digit stage. That stage presents a digit 0-9 on num, latched one cycle after its run_in is high.
- This block edge-detects the same run_in button level and samples num on the cycle after each rising edge.
- It shifts DIGITS samples into a BCD register, then converts the BCD number to binary with a sequential multiply-by-10 accumulator.
- It publishes the binary result with a one-cycle valid strobe for the factorization logic.

---
 rtl/digit_collector.sv | 146 ++++++++++++++
 tb/tb_digit_collector.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_collector.sv
// Collects DIGITS decimal digits from the random-digit stage on run_in rising edges,
// then converts the BCD number to binary and strobes valid for one cycle.
module digit_collector #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned VW     = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run_in,
  input  logic [3:0]            num,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [2:0]            ndig,
  output logic                  busy,
  output logic [VW-1:0]         value,
  output logic                  valid,
  output logic                  err
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = VW + 4;

  typedef enum logic {COLLECT, CONVERT} state_t;

  state_t          state_q, state_d;
  logic            run_d;
  logic            pend, pend_d;
  logic [VW-1:0]   acc, acc_d;
  logic [IW-1:0]   idx, idx_d;
  logic [BW-1:0]   bcd_d;
  logic [2:0]      ndig_d;
  logic            busy_d, valid_d, err_d;
  logic [VW-1:0]   value_d;

  logic            rise_c;
  logic            bad_c;
  logic [3:0]      dig_c;
  logic [3:0]      dsel_c;
  logic [PW-1:0]   prod_c;
  logic [VW-1:0]   step_c;

  assign rise_c = run_in & ~run_d;
  assign bad_c  = (num > 4'd9);
  assign dig_c  = bad_c ? 4'd9 : num;

  // Digit addressed by idx, most significant first during conversion
  always_comb begin
    dsel_c = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IW'(i)) dsel_c = bcd[4*i +: 4];
    end
  end

  // acc*10 as shift-add, kept at PW bits before truncation
  assign prod_c = (PW'(acc) << 3) + (PW'(acc) << 1);
  assign step_c = VW'(prod_c) + VW'(dsel_c);

  // Next-state and datapath updates; clr overrides everything but value
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    acc_d   = acc;
    idx_d   = idx;
    bcd_d   = bcd;
    ndig_d  = ndig;
    busy_d  = busy;
    value_d = value;
    valid_d = 1'b0;
    err_d   = err;

    if (clr) begin
      state_d = COLLECT;
      acc_d   = '0;
      idx_d   = '0;
      bcd_d   = '0;
      ndig_d  = 3'd0;
      busy_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          pend_d = rise_c;
          if (pend) begin
            if (ndig == 3'd0) begin
              bcd_d = BW'(dig_c);
              err_d = bad_c;
            end else begin
              bcd_d = (bcd << 4) | BW'(dig_c);
              err_d = err | bad_c;
            end
            ndig_d = ndig + 3'd1;
            if (ndig == 3'(DIGITS - 1)) begin
              state_d = CONVERT;
              busy_d  = 1'b1;
              acc_d   = '0;
              idx_d   = IW'(DIGITS - 1);
            end
          end
        end
        CONVERT: begin
          acc_d = step_c;
          if (idx == '0) begin
            value_d = step_c;
            valid_d = 1'b1;
            ndig_d  = 3'd0;
            busy_d  = 1'b0;
            state_d = COLLECT;
          end else begin
            idx_d = idx - IW'(1);
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= COLLECT;
      run_d   <= 1'b0;
      pend    <= 1'b0;
      acc     <= '0;
      idx     <= '0;
      bcd     <= '0;
      ndig    <= 3'd0;
      busy    <= 1'b0;
      value   <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      run_d   <= run_in;
      pend    <= pend_d;
      acc     <= acc_d;
      idx     <= idx_d;
      bcd     <= bcd_d;
      ndig    <= ndig_d;
      busy    <= busy_d;
      value   <= value_d;
      valid   <= valid_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_digit_collector.sv
// Bench for digit_collector: directed scenarios plus random numbers on a 3-digit
// and a 4-digit instance, compared against a decimal arithmetic reference.
module tb_digit_collector;

  logic CLK = 1'b0;
  logic RST;

  logic        run3, clr3;
  logic [3:0]  num3;
  logic [11:0] bcd3;
  logic [2:0]  ndig3;
  logic        busy3, valid3, err3;
  logic [9:0]  value3;

  logic        run4, clr4;
  logic [3:0]  num4;
  logic [15:0] bcd4;
  logic [2:0]  ndig4;
  logic        busy4, valid4, err4;
  logic [13:0] value4;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  digit_collector #(.DIGITS(3), .VW(10)) dut3 (
    .CLK(CLK), .RST(RST), .run_in(run3), .num(num3), .clr(clr3),
    .bcd(bcd3), .ndig(ndig3), .busy(busy3), .value(value3), .valid(valid3), .err(err3)
  );

  digit_collector #(.DIGITS(4), .VW(14)) dut4 (
    .CLK(CLK), .RST(RST), .run_in(run4), .num(num4), .clr(clr4),
    .bcd(bcd4), .ndig(ndig4), .busy(busy4), .value(value4), .valid(valid4), .err(err4)
  );

  // Reference: decimal value of a digit string, out-of-range digits read as 9
  function automatic int ref_value(input int d[$]);
    int v = 0;
    int p = 1;
    for (int i = d.size() - 1; i >= 0; i--) begin
      v += ((d[i] > 9) ? 9 : d[i]) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic int ref_bcd(input int d[$]);
    int b = 0;
    for (int i = 0; i < d.size(); i++) b = b * 16 + ((d[i] > 9) ? 9 : d[i]);
    return b;
  endfunction

  // One button press: digit held until the clock after the detected edge
  task automatic cap3(input int d);
    @(negedge CLK); run3 = 1'b1; num3 = 4'(d);
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); run3 = 1'b0;
  endtask

  task automatic cap4(input int d);
    @(negedge CLK); run4 = 1'b1; num4 = 4'(d);
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); run4 = 1'b0;
  endtask

  // Observes the cycles after the final capture; optionally presses run_in while busy
  task automatic watch3(input bit poke, output int vcyc, output int nbusy,
                        output int nvalid, output logic [9:0] vval);
    vcyc = -1; nbusy = 0; nvalid = 0; vval = 'x;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge CLK);
      if (poke && i == 1) run3 = 1'b1;
      if (poke && i == 3) run3 = 1'b0;
      if (busy3) nbusy++;
      if (valid3) begin
        nvalid++;
        if (vcyc < 0) begin vcyc = i; vval = value3; end
      end
    end
  endtask

  task automatic watch4(output int vcyc, output int nbusy,
                        output int nvalid, output logic [13:0] vval);
    vcyc = -1; nbusy = 0; nvalid = 0; vval = 'x;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge CLK);
      if (busy4) nbusy++;
      if (valid4) begin
        nvalid++;
        if (vcyc < 0) begin vcyc = i; vval = value4; end
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; run3 = 1'b1; num3 = 4'd7; clr3 = 1'b0;
    run4 = 1'b1; num4 = 4'd7; clr4 = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({bcd3, ndig3, busy3, value3, valid3, err3} !== '0) begin
      errors++;
      $display("FAIL reset3: bcd=%h ndig=%0d busy=%b value=%0d valid=%b err=%b",
               bcd3, ndig3, busy3, value3, valid3, err3);
    end
    checks++;
    if ({bcd4, ndig4, busy4, value4, valid4, err4} !== '0) begin
      errors++;
      $display("FAIL reset4: bcd=%h ndig=%0d busy=%b value=%0d valid=%b err=%b",
               bcd4, ndig4, busy4, value4, valid4, err4);
    end
    RST = 1'b0; run3 = 1'b0; run4 = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if (ndig3 !== 3'd0) begin
      errors++; $display("FAIL reset_nocap: ndig=%0d want 0", ndig3);
    end
  endtask

  task automatic test_nominal;
    int vc, nb, nv; logic [9:0] vv;
    int want_n[3] = '{1, 2, 3};
    int d[3] = '{4, 0, 7};
    for (int i = 0; i < 3; i++) begin
      cap3(d[i]);
      checks++;
      if (ndig3 !== 3'(want_n[i])) begin
        errors++; $display("FAIL nominal_ndig%0d: got %0d want %0d", i, ndig3, want_n[i]);
      end
    end
    watch3(1'b0, vc, nb, nv, vv);
    checks++;
    if (vv !== 10'd407 || bcd3 !== 12'h407) begin
      errors++; $display("FAIL nominal_value: value=%0d bcd=%h want 407/407", vv, bcd3);
    end
    checks++;
    if (vc !== 3 || nb !== 3 || nv !== 1) begin
      errors++; $display("FAIL nominal_timing: vcyc=%0d busy=%0d valids=%0d want 3/3/1", vc, nb, nv);
    end
    checks++;
    if (ndig3 !== 3'd0) begin
      errors++; $display("FAIL nominal_ndig_end: got %0d want 0", ndig3);
    end
  endtask

  task automatic test_leading_zeros;
    int vc, nb, nv; logic [9:0] vv;
    cap3(0); cap3(0); cap3(5);
    watch3(1'b0, vc, nb, nv, vv);
    checks++;
    if (vv !== 10'd5 || vc !== 3) begin
      errors++; $display("FAIL lead_zero: value=%0d vcyc=%0d want 5/3", vv, vc);
    end
    cap3(9);
    checks++;
    if (bcd3 !== 12'h009) begin
      errors++; $display("FAIL lead_bcd_clear: bcd=%h want 009", bcd3);
    end
    cap3(9); cap3(9);
    watch3(1'b0, vc, nb, nv, vv);
    checks++;
    if (vv !== 10'd999 || nv !== 1) begin
      errors++; $display("FAIL lead_999: value=%0d valids=%0d want 999/1", vv, nv);
    end
  endtask

  task automatic test_edge_in_convert;
    int vc, nb, nv; logic [9:0] vv;
    cap3(6); cap3(4); cap3(2);
    watch3(1'b1, vc, nb, nv, vv);
    checks++;
    if (vv !== 10'd642 || value3 !== 10'd642 || nv !== 1) begin
      errors++; $display("FAIL busy_edge_value: value=%0d valids=%0d want 642/1", vv, nv);
    end
    checks++;
    if (ndig3 !== 3'd0 || bcd3 !== 12'h642) begin
      errors++; $display("FAIL busy_edge_ignored: ndig=%0d bcd=%h want 0/642", ndig3, bcd3);
    end
  endtask

  task automatic test_clr;
    int vc, nb, nv; logic [9:0] vv;
    cap3(3); cap3(8);
    checks++;
    if (ndig3 !== 3'd2 || bcd3 !== 12'h038) begin
      errors++; $display("FAIL clr_pre: ndig=%0d bcd=%h want 2/038", ndig3, bcd3);
    end
    @(negedge CLK); clr3 = 1'b1;
    @(negedge CLK); clr3 = 1'b0;
    checks++;
    if (ndig3 !== 3'd0 || bcd3 !== 12'h000 || value3 !== 10'd642) begin
      errors++; $display("FAIL clr_alone: ndig=%0d bcd=%h value=%0d want 0/000/642", ndig3, bcd3, value3);
    end
    cap3(1); cap3(2);
    checks++;
    if (value3 !== 10'd642) begin
      errors++; $display("FAIL clr_value_hold: value=%0d want 642", value3);
    end
    cap3(3);
    watch3(1'b0, vc, nb, nv, vv);
    checks++;
    if (vv !== 10'd123 || vc !== 3) begin
      errors++; $display("FAIL clr_then_123: value=%0d vcyc=%0d want 123/3", vv, vc);
    end
    // clr coincides with the clock that would capture the last digit
    cap3(7); cap3(7);
    @(negedge CLK); run3 = 1'b1; num3 = 4'd7;
    @(posedge CLK);
    @(negedge CLK); clr3 = 1'b1;
    @(posedge CLK);
    @(negedge CLK); clr3 = 1'b0; run3 = 1'b0;
    watch3(1'b0, vc, nb, nv, vv);
    checks++;
    if (nb !== 0 || nv !== 0 || ndig3 !== 3'd0 || value3 !== 10'd123) begin
      errors++; $display("FAIL clr_final: busy=%0d valids=%0d ndig=%0d value=%0d want 0/0/0/123",
                         nb, nv, ndig3, value3);
    end
  endtask

  task automatic test_err;
    int vc, nb, nv; logic [9:0] vv;
    cap3(5); cap3(12);
    checks++;
    if (err3 !== 1'b1) begin
      errors++; $display("FAIL err_set: err=%b want 1", err3);
    end
    cap3(1);
    watch3(1'b0, vc, nb, nv, vv);
    checks++;
    if (vv !== 10'd591 || err3 !== 1'b1) begin
      errors++; $display("FAIL err_591: value=%0d err=%b want 591/1", vv, err3);
    end
    cap3(2);
    checks++;
    if (err3 !== 1'b0) begin
      errors++; $display("FAIL err_clear: err=%b want 0", err3);
    end
    @(negedge CLK); clr3 = 1'b1;
    @(negedge CLK); clr3 = 1'b0;
  endtask

  task automatic test_four_digits;
    int vc, nb, nv; logic [13:0] vv;
    int q[$];
    for (int i = 0; i < 4; i++) cap4(9);
    watch4(vc, nb, nv, vv);
    checks++;
    if (vv !== 14'd9999 || vc !== 4 || nb !== 4 || nv !== 1) begin
      errors++; $display("FAIL four_9999: value=%0d vcyc=%0d busy=%0d valids=%0d want 9999/4/4/1",
                         vv, vc, nb, nv);
    end
    for (int n = 0; n < 6; n++) begin
      q.delete();
      for (int i = 0; i < 4; i++) begin
        q.push_back(int'($urandom_range(0, 9)));
        cap4(q[i]);
      end
      watch4(vc, nb, nv, vv);
      checks++;
      if (vv !== 14'(ref_value(q)) || vc !== 4 || bcd4 !== 16'(ref_bcd(q))) begin
        errors++; $display("FAIL four_rand%0d: value=%0d bcd=%h vcyc=%0d want %0d/%h/4",
                           n, vv, bcd4, vc, ref_value(q), ref_bcd(q));
      end
    end
  endtask

  task automatic test_random;
    int vc, nb, nv; logic [9:0] vv;
    int q[$];
    logic bad;
    for (int n = 0; n < 15; n++) begin
      q.delete(); bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
        q.push_back(int'($urandom_range(0, 11)));
        if (q[i] > 9) bad = 1'b1;
        cap3(q[i]);
      end
      watch3(1'b0, vc, nb, nv, vv);
      checks++;
      if (vv !== 10'(ref_value(q)) || vc !== 3 || nv !== 1 || err3 !== bad
          || bcd3 !== 12'(ref_bcd(q))) begin
        errors++; $display("FAIL rand%0d: value=%0d vcyc=%0d valids=%0d err=%b bcd=%h want %0d/3/1/%b/%h",
                           n, vv, vc, nv, err3, bcd3, ref_value(q), bad, ref_bcd(q));
      end
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_leading_zeros;
    test_edge_in_convert;
    test_clr;
    test_err;
    test_four_digits;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
